// File: rtl/CSR_UnitTypes.sv
// CSR_UnitTypes: shared types for the trap sequencer and its interrupt selector.
// Holds the CSR body layout, PC/code widths, the sequencer state and trap-kind
// enums, and the HOLDOFF counter width.
package CSR_UnitTypes;

  localparam int unsigned PC_WIDTH           = 32;
  localparam int unsigned CSR_WIDTH          = 32;
  localparam int unsigned INT_CODE_WIDTH     = 4;
  localparam int unsigned TRAP_HOLDOFF_WIDTH = 8;

  typedef logic [PC_WIDTH-1:0]           PC_Path;
  typedef logic [CSR_WIDTH-1:0]          CSR_Path;
  typedef logic [INT_CODE_WIDTH-1:0]     InterruptCodePath;
  typedef logic [TRAP_HOLDOFF_WIDTH-1:0] TrapHoldoffCountPath;

  // Commit-stage outcome reported alongside excptReq
  typedef enum logic [2:0] {
    EXEC_STATE_SUCCESS,
    EXEC_STATE_REFETCH_NEXT,
    EXEC_STATE_TRAP_ECALL,
    EXEC_STATE_TRAP_EBREAK,
    EXEC_STATE_TRAP_MRET,
    EXEC_STATE_FAULT_LOAD,
    EXEC_STATE_FAULT_STORE,
    EXEC_STATE_FAULT_INSN
  } ExecutionState;

  // Machine-mode CSRs the sequencer needs to see
  typedef struct packed {
    CSR_Path mstatus;
    CSR_Path mie;
    CSR_Path mip;
  } CSR_BodyPath;

  localparam int unsigned MSTATUS_MIE_BIT = 3;
  localparam int unsigned MIE_MTIE_BIT    = 7;
  localparam int unsigned MIE_MEIE_BIT    = 11;
  localparam int unsigned MIP_MTIP_BIT    = 7;
  localparam int unsigned MIP_MEIP_BIT    = 11;

  localparam InterruptCodePath INT_CODE_TIMER    = 4'd7;
  localparam InterruptCodePath INT_CODE_EXTERNAL = 4'd11;

  typedef enum logic [2:0] {
    TRAP_SEQ_IDLE,
    TRAP_SEQ_DRAIN,
    TRAP_SEQ_FIRE,
    TRAP_SEQ_REDIRECT,
    TRAP_SEQ_HOLDOFF
  } TrapSeqState;

  typedef enum logic {
    TRAP_KIND_EXCPT,
    TRAP_KIND_INT
  } TrapKind;

endpackage

// File: rtl/trap_int_select.sv
// trap_int_select: combinational interrupt pending/cause selection.
// Optional feature macro: RSD_TRAP_SEQ_EXT_INT_EN (adds the MEIE/MEIP term).
// Ports:
//   csrWhole  in   mstatus/mie/mip snapshot
//   pending   out  an enabled machine interrupt is pending
//   code      out  cause code of the winning interrupt (external beats timer)
module trap_int_select
  import CSR_UnitTypes::*;
(
  input  CSR_BodyPath      csrWhole,
  output logic             pending,
  output InterruptCodePath code
);

  logic global_en;
  logic timer_hit;
  logic ext_hit;

  // Pending/cause decode; external has priority over timer
  always_comb begin
    global_en = csrWhole.mstatus[MSTATUS_MIE_BIT];
    timer_hit = csrWhole.mie[MIE_MTIE_BIT] & csrWhole.mip[MIP_MTIP_BIT];
`ifdef RSD_TRAP_SEQ_EXT_INT_EN
    ext_hit   = csrWhole.mie[MIE_MEIE_BIT] & csrWhole.mip[MIP_MEIP_BIT];
`else
    ext_hit   = 1'b0;
`endif
    pending   = global_en & (ext_hit | timer_hit);
    code      = ext_hit ? INT_CODE_EXTERNAL : INT_CODE_TIMER;
  end

  // Only a handful of CSR bits matter here
  logic unused_csr_bits;
  assign unused_csr_bits = ^csrWhole;

endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences exceptions/interrupts from commit through pipeline
// drain, CSR trigger pulse, fetch redirect and a post-redirect holdoff window.
// Optional feature macro: RSD_TRAP_SEQ_EXT_INT_EN (external interrupt support,
// handled inside trap_int_select).
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   excptReq/excptCause commit-stage exception or MRET request and its cause
//   intRetPC            PC of the oldest uncommitted instruction
//   csrWhole            mstatus/mie/mip snapshot
//   pipeEmpty           backend drained after flush
//   redirectAck         fetch accepted the redirect
//   csrWriteReq         CSR instruction write request
//   csrWriteGrant       write permitted this cycle (combinational)
//   triggerExcpt        one-cycle pulse to CSR unit for an exception
//   triggerInterrupt    one-cycle pulse to CSR unit for an interrupt
//   interruptCode       latched interrupt cause code
//   interruptRetAddr    latched return PC
//   flushReq            asserted in every DRAIN cycle
//   redirectValid       held until redirectAck
//   busy                sequencer not idle
module trap_sequencer
  import CSR_UnitTypes::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             excptReq,
  input  ExecutionState    excptCause,
  input  PC_Path           intRetPC,
  input  CSR_BodyPath      csrWhole,
  input  logic             pipeEmpty,
  input  logic             redirectAck,
  input  logic             csrWriteReq,
  output logic             csrWriteGrant,
  output logic             triggerExcpt,
  output logic             triggerInterrupt,
  output InterruptCodePath interruptCode,
  output PC_Path           interruptRetAddr,
  output logic             flushReq,
  output logic             redirectValid,
  output logic             busy
);

  logic             int_pending;
  InterruptCodePath int_code;

  trap_int_select u_int_select (
    .csrWhole (csrWhole),
    .pending  (int_pending),
    .code     (int_code)
  );

  TrapSeqState         state_q,          state_d;
  TrapKind             kind_q,           kind_d;
  InterruptCodePath    code_q,           code_d;
  PC_Path              ret_pc_q,         ret_pc_d;
  TrapHoldoffCountPath holdoff_q,        holdoff_d;
  logic                flush_req_q,      flush_req_d;
  logic                trig_excpt_q,     trig_excpt_d;
  logic                trig_int_q,       trig_int_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic                busy_q,           busy_d;

  // Next-state, latches and next-cycle output decode
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    code_d    = code_q;
    ret_pc_d  = ret_pc_q;
    holdoff_d = holdoff_q;

    case (state_q)
      TRAP_SEQ_IDLE: begin
        if (excptReq) begin
          state_d  = TRAP_SEQ_DRAIN;
          kind_d   = TRAP_KIND_EXCPT;
          code_d   = int_code;
          ret_pc_d = intRetPC;
        end else if (csrWriteReq) begin
          // Granted CSR write owns this cycle; interrupts wait
          state_d = TRAP_SEQ_IDLE;
        end else if (int_pending) begin
          state_d  = TRAP_SEQ_DRAIN;
          kind_d   = TRAP_KIND_INT;
          code_d   = int_code;
          ret_pc_d = intRetPC;
        end
      end
      TRAP_SEQ_DRAIN: begin
        // A withdrawn interrupt is dropped; exceptions always complete
        if ((kind_q == TRAP_KIND_INT) && !int_pending) begin
          state_d = TRAP_SEQ_IDLE;
        end else if (pipeEmpty) begin
          state_d = TRAP_SEQ_FIRE;
        end
      end
      TRAP_SEQ_FIRE: begin
        state_d = TRAP_SEQ_REDIRECT;
      end
      TRAP_SEQ_REDIRECT: begin
        if (redirectAck) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_d = TRAP_SEQ_IDLE;
          end else begin
            state_d   = TRAP_SEQ_HOLDOFF;
            holdoff_d = TrapHoldoffCountPath'(HOLDOFF_CYCLES);
          end
        end
      end
      TRAP_SEQ_HOLDOFF: begin
        if (holdoff_q <= TrapHoldoffCountPath'(1)) begin
          state_d   = TRAP_SEQ_IDLE;
          holdoff_d = '0;
        end else begin
          holdoff_d = holdoff_q - TrapHoldoffCountPath'(1);
        end
      end
      default: begin
        state_d = TRAP_SEQ_IDLE;
      end
    endcase

    // Outputs are registered, so decode them from the upcoming state
    flush_req_d      = (state_d == TRAP_SEQ_DRAIN);
    trig_excpt_d     = (state_d == TRAP_SEQ_FIRE) && (kind_d == TRAP_KIND_EXCPT);
    trig_int_d       = (state_d == TRAP_SEQ_FIRE) && (kind_d == TRAP_KIND_INT);
    redirect_valid_d = (state_d == TRAP_SEQ_REDIRECT);
    busy_d           = (state_d != TRAP_SEQ_IDLE);
  end

  // State, latches and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= TRAP_SEQ_IDLE;
      kind_q           <= TRAP_KIND_EXCPT;
      code_q           <= '0;
      ret_pc_q         <= '0;
      holdoff_q        <= '0;
      flush_req_q      <= 1'b0;
      trig_excpt_q     <= 1'b0;
      trig_int_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      kind_q           <= kind_d;
      code_q           <= code_d;
      ret_pc_q         <= ret_pc_d;
      holdoff_q        <= holdoff_d;
      flush_req_q      <= flush_req_d;
      trig_excpt_q     <= trig_excpt_d;
      trig_int_q       <= trig_int_d;
      redirect_valid_q <= redirect_valid_d;
      busy_q           <= busy_d;
    end
  end

  // Same-cycle grant; gated by reset so every output is 0 while reset is held
  assign csrWriteGrant = rst & csrWriteReq & (state_q == TRAP_SEQ_IDLE) & ~excptReq;

  assign triggerExcpt     = trig_excpt_q;
  assign triggerInterrupt = trig_int_q;
  assign interruptCode    = code_q;
  assign interruptRetAddr = ret_pc_q;
  assign flushReq         = flush_req_q;
  assign redirectValid    = redirect_valid_q;
  assign busy             = busy_q;

  // Cause is consumed by the CSR unit, not by the sequencing itself
  logic unused_cause;
  assign unused_cause = ^excptCause;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed bench for trap_sequencer with a pulse scoreboard.
module tb_trap_sequencer;
  import CSR_UnitTypes::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             excptReq;
  ExecutionState    excptCause;
  PC_Path           intRetPC;
  CSR_BodyPath      csrWhole;
  logic             pipeEmpty;
  logic             redirectAck;
  logic             csrWriteReq;
  logic             csrWriteGrant;
  logic             triggerExcpt;
  logic             triggerInterrupt;
  InterruptCodePath interruptCode;
  PC_Path           interruptRetAddr;
  logic             flushReq;
  logic             redirectValid;
  logic             busy;

  // Second instance exercising HOLDOFF_CYCLES = 0
  logic             excptReq0;
  CSR_BodyPath      csrWhole0;
  logic             csrWriteReq0;
  logic             csrWriteGrant0;
  logic             triggerExcpt0;
  logic             triggerInterrupt0;
  InterruptCodePath interruptCode0;
  PC_Path           interruptRetAddr0;
  logic             flushReq0;
  logic             redirectValid0;
  logic             busy0;

  always #5 clk = ~clk;

  trap_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .excptReq         (excptReq),
    .excptCause       (excptCause),
    .intRetPC         (intRetPC),
    .csrWhole         (csrWhole),
    .pipeEmpty        (pipeEmpty),
    .redirectAck      (redirectAck),
    .csrWriteReq      (csrWriteReq),
    .csrWriteGrant    (csrWriteGrant),
    .triggerExcpt     (triggerExcpt),
    .triggerInterrupt (triggerInterrupt),
    .interruptCode    (interruptCode),
    .interruptRetAddr (interruptRetAddr),
    .flushReq         (flushReq),
    .redirectValid    (redirectValid),
    .busy             (busy)
  );

  trap_sequencer #(.HOLDOFF_CYCLES(0)) dut0 (
    .clk              (clk),
    .rst              (rst),
    .excptReq         (excptReq0),
    .excptCause       (excptCause),
    .intRetPC         (intRetPC),
    .csrWhole         (csrWhole0),
    .pipeEmpty        (pipeEmpty),
    .redirectAck      (redirectAck),
    .csrWriteReq      (csrWriteReq0),
    .csrWriteGrant    (csrWriteGrant0),
    .triggerExcpt     (triggerExcpt0),
    .triggerInterrupt (triggerInterrupt0),
    .interruptCode    (interruptCode0),
    .interruptRetAddr (interruptRetAddr0),
    .flushReq         (flushReq0),
    .redirectValid    (redirectValid0),
    .busy             (busy0)
  );

`ifdef RSD_TRAP_SEQ_EXT_INT_EN
  localparam InterruptCodePath BOTH_CODE = INT_CODE_EXTERNAL;
`else
  localparam InterruptCodePath BOTH_CODE = INT_CODE_TIMER;
`endif

  typedef struct packed {
    logic             is_int;
    InterruptCodePath code;
    PC_Path           pc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_int, input InterruptCodePath code, input PC_Path pc);
    exp_t e;
    e.is_int = is_int;
    e.code   = code;
    e.pc     = pc;
    sb_q.push_back(e);
  endtask

  function automatic CSR_BodyPath mk_csr(input logic g, input logic meie, input logic mtie,
                                         input logic meip, input logic mtip);
    CSR_BodyPath c;
    c = '0;
    c.mstatus[MSTATUS_MIE_BIT] = g;
    c.mie[MIE_MEIE_BIT]        = meie;
    c.mie[MIE_MTIE_BIT]        = mtie;
    c.mip[MIP_MEIP_BIT]        = meip;
    c.mip[MIP_MTIP_BIT]        = mtip;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every trigger pulse must match the oldest expected trap
  always @(negedge clk) begin
    if (triggerExcpt || triggerInterrupt || csrWriteGrant)
      chkb("pulse_exclusive", $onehot({triggerExcpt, triggerInterrupt, csrWriteGrant}), 1'b1);
    if (triggerExcpt || triggerInterrupt) begin
      chkb("pulse_expected", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chkb("pulse_kind_int", triggerInterrupt, e.is_int);
        chk("pulse_ret_pc", interruptRetAddr, e.pc);
        if (e.is_int) chk("pulse_code", 32'(interruptCode), 32'(e.code));
      end
    end
  end

  initial begin
    rst          = 1'b0;
    excptReq     = 1'b0;
    excptCause   = EXEC_STATE_TRAP_ECALL;
    intRetPC     = '0;
    csrWhole     = '0;
    pipeEmpty    = 1'b0;
    redirectAck  = 1'b0;
    csrWriteReq  = 1'b0;
    excptReq0    = 1'b0;
    csrWhole0    = '0;
    csrWriteReq0 = 1'b0;
    #12;
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_flush", flushReq, 1'b0);
    chkb("rst_redirect", redirectValid, 1'b0);
    chk("rst_code", 32'(interruptCode), 32'd0);
    chk("rst_pc", interruptRetAddr, 32'd0);
    step();
    rst = 1'b1;
    step();

    // A: timer interrupt, latency and redirect handshake with HOLDOFF=2
    csrWhole  = mk_csr(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    pipeEmpty = 1'b1;
    intRetPC  = 32'h100;
    push_exp(1'b1, INT_CODE_TIMER, 32'h100);
    #1 chkb("A_c0_busy", busy, 1'b0);
    step();
    chkb("A_c1_flush", flushReq, 1'b1);
    chkb("A_c1_trig", triggerInterrupt, 1'b0);
    chk("A_c1_code", 32'(interruptCode), 32'(INT_CODE_TIMER));
    chk("A_c1_pc", interruptRetAddr, 32'h100);
    step();
    chkb("A_c2_trig", triggerInterrupt, 1'b1);
    chkb("A_c2_flush", flushReq, 1'b0);
    csrWhole = mk_csr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chkb("A_c3_redirect", redirectValid, 1'b1);
    step();
    chkb("A_c4_redirect_hold", redirectValid, 1'b1);
    redirectAck = 1'b1;
    step();
    chkb("A_c5_redirect", redirectValid, 1'b0);
    chkb("A_c5_busy", busy, 1'b1);
    redirectAck = 1'b0;
    step();
    chkb("A_c6_busy", busy, 1'b1);
    step();
    chkb("A_c7_busy", busy, 1'b0);

    // B: external + timer together, holdoff blocks a second trap
    csrWhole    = mk_csr(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    intRetPC    = 32'h200;
    redirectAck = 1'b1;
    push_exp(1'b1, BOTH_CODE, 32'h200);
    step();
    chk("B_c1_code", 32'(interruptCode), 32'(BOTH_CODE));
    chkb("B_c1_flush", flushReq, 1'b1);
    step();
    chkb("B_c2_trig", triggerInterrupt, 1'b1);
    step();
    chkb("B_c3_redirect", redirectValid, 1'b1);
    step();
    chkb("B_c4_busy", busy, 1'b1);
    chkb("B_c4_redirect", redirectValid, 1'b0);
    chkb("B_c4_flush", flushReq, 1'b0);
    step();
    chkb("B_c5_busy", busy, 1'b1);
    chkb("B_c5_flush", flushReq, 1'b0);
    intRetPC = 32'h204;
    push_exp(1'b1, BOTH_CODE, 32'h204);
    step();
    chkb("B_c6_busy", busy, 1'b0);
    step();
    chkb("B_c7_flush", flushReq, 1'b1);
    step();
    chkb("B_c8_trig", triggerInterrupt, 1'b1);
    csrWhole = '0;
    step();
    chkb("B_c9_redirect", redirectValid, 1'b1);
    step();
    redirectAck = 1'b0;
    step();
    step();
    chkb("B_c12_busy", busy, 1'b0);

    // C: exception beats pending interrupt and blocks the CSR grant
    csrWhole    = mk_csr(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    excptReq    = 1'b1;
    csrWriteReq = 1'b1;
    intRetPC    = 32'h300;
    pipeEmpty   = 1'b0;
    push_exp(1'b0, '0, 32'h300);
    #1 chkb("C_grant_vs_excpt", csrWriteGrant, 1'b0);
    step();
    chkb("C_c1_flush", flushReq, 1'b1);
    intRetPC = 32'h3FC;
    csrWhole = '0;
    #1 chkb("C_grant_busy", csrWriteGrant, 1'b0);
    step();
    chkb("C_c2_flush", flushReq, 1'b1);
    chk("C_c2_pc", interruptRetAddr, 32'h300);
    pipeEmpty = 1'b1;
    step();
    chkb("C_c3_trig_excpt", triggerExcpt, 1'b1);
    chkb("C_c3_trig_int", triggerInterrupt, 1'b0);
    excptReq    = 1'b0;
    csrWriteReq = 1'b0;
    step();
    chkb("C_c4_redirect", redirectValid, 1'b1);
    redirectAck = 1'b1;
    step();
    redirectAck = 1'b0;
    step();
    step();
    chkb("C_c7_busy", busy, 1'b0);

    // D: interrupt withdrawn during DRAIN aborts without a pulse
    csrWhole  = mk_csr(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    pipeEmpty = 1'b0;
    intRetPC  = 32'h400;
    step();
    chkb("D_c1_flush", flushReq, 1'b1);
    csrWhole = mk_csr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chkb("D_c2_busy", busy, 1'b0);
    chkb("D_c2_flush", flushReq, 1'b0);
    csrWhole = '0;
    step();
    step();
    chkb("D_c4_busy", busy, 1'b0);

    // E: CSR grant defers the interrupt; async reset while in REDIRECT
    csrWhole    = mk_csr(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    csrWriteReq = 1'b1;
    pipeEmpty   = 1'b1;
    intRetPC    = 32'h500;
    #1 chkb("E_grant", csrWriteGrant, 1'b1);
    step();
    chkb("E_c1_not_accepted", busy, 1'b0);
    csrWriteReq = 1'b0;
    push_exp(1'b1, INT_CODE_TIMER, 32'h500);
    step();
    chkb("E_c2_flush", flushReq, 1'b1);
    step();
    chkb("E_c3_trig", triggerInterrupt, 1'b1);
    csrWhole = '0;
    step();
    chkb("E_c4_redirect", redirectValid, 1'b1);
    csrWriteReq = 1'b1;
    #2 rst = 1'b0;
    #1;
    chkb("E_rst_busy", busy, 1'b0);
    chkb("E_rst_redirect", redirectValid, 1'b0);
    chkb("E_rst_flush", flushReq, 1'b0);
    chkb("E_rst_trig_e", triggerExcpt, 1'b0);
    chkb("E_rst_trig_i", triggerInterrupt, 1'b0);
    chkb("E_rst_grant", csrWriteGrant, 1'b0);
    chk("E_rst_code", 32'(interruptCode), 32'd0);
    chk("E_rst_pc", interruptRetAddr, 32'd0);
    step();
    rst         = 1'b1;
    csrWriteReq = 1'b0;
    step();
    step();
    chkb("E_post_busy", busy, 1'b0);

    // F: exception dropped by reset during DRAIN never fires later
    excptReq  = 1'b1;
    pipeEmpty = 1'b0;
    intRetPC  = 32'h600;
    step();
    chkb("F_c1_flush", flushReq, 1'b1);
    #2 rst = 1'b0;
    #1 chkb("F_rst_busy", busy, 1'b0);
    excptReq = 1'b0;
    step();
    rst       = 1'b1;
    pipeEmpty = 1'b1;
    step();
    step();
    step();
    chkb("F_post_busy", busy, 1'b0);
    chkb("F_post_trig", triggerExcpt, 1'b0);

    // G: HOLDOFF_CYCLES=0 returns to IDLE straight from REDIRECT
    excptReq0   = 1'b1;
    pipeEmpty   = 1'b1;
    redirectAck = 1'b1;
    intRetPC    = 32'h700;
    #1 chkb("G_grant0", csrWriteGrant0, 1'b0);
    step();
    chkb("G_c1_flush0", flushReq0, 1'b1);
    excptReq0 = 1'b0;
    step();
    chkb("G_c2_trig0", triggerExcpt0, 1'b1);
    chkb("G_c2_trig_int0", triggerInterrupt0, 1'b0);
    chk("G_c2_pc0", interruptRetAddr0, 32'h700);
    chk("G_c2_code0", 32'(interruptCode0), 32'(INT_CODE_TIMER));
    step();
    chkb("G_c3_redirect0", redirectValid0, 1'b1);
    step();
    chkb("G_c4_busy0", busy0, 1'b0);
    chkb("G_c4_redirect0", redirectValid0, 1'b0);
    redirectAck = 1'b0;
    step();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter HOLDOFF_CYCLES, default 2, meaning the number of idle cycles after a redirect before a new trap is accepted (0 allowed).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 excptReq  in  1  commit stage reports an exception or MRET; held high until triggerExcpt is seen.
REQ-006 excptCause  in  ExecutionState  cause for excptReq.
REQ-007 intRetPC  in  PC_Path  PC of the oldest uncommitted instruction.
REQ-008 csrWhole  in  CSR_BodyPath  current CSR contents (mstatus, mie, mip).
REQ-009 pipeEmpty  in  1  backend drained after flush.
REQ-010 redirectAck  in  1  fetch accepted the redirect.
REQ-011 csrWriteReq  in  1  CSR instruction requests a write; csrWriteGrant  out  1  write permitted this cycle.
REQ-012 triggerExcpt, triggerInterrupt  out  1 each  one-cycle pulses to the CSR unit.
REQ-013 interruptCode  out  InterruptCodePath; interruptRetAddr  out  PC_Path; flushReq, redirectValid, busy  out  1 each.

Function
REQ-014 pending SHALL equal mstatus.MIE & ((mie.MEIE & mip.MEIP) | (mie.MTIE & mip.MTIP)); external interrupts SHALL win over timer interrupts.
REQ-015 States SHALL be IDLE, DRAIN, FIRE, REDIRECT, HOLDOFF; busy = (state != IDLE).
REQ-016 In IDLE, priority SHALL be excptReq > csrWriteReq > pending; csrWriteGrant = csrWriteReq & IDLE & !excptReq, and no interrupt is accepted in a granted cycle.
REQ-017 On acceptance, the block SHALL latch kind (EXCPT/INT), the interrupt code, and intRetPC, then go to DRAIN.
REQ-018 flushReq SHALL be high for every DRAIN cycle.
REQ-019 In DRAIN, pipeEmpty=1 SHALL move to FIRE.
REQ-020 In DRAIN with kind INT, if pending drops the block SHALL abort to IDLE with no trigger pulse; an exception never aborts.
REQ-021 FIRE SHALL last exactly one cycle, pulsing triggerExcpt (EXCPT) or triggerInterrupt (INT), then go to REDIRECT.
REQ-022 triggerExcpt, triggerInterrupt and csrWriteGrant SHALL never be high together.
REQ-023 REDIRECT SHALL hold redirectValid until redirectAck; if redirectAck is already high in the first REDIRECT cycle, the exit SHALL happen that same cycle.
REQ-024 On leaving REDIRECT, the block SHALL load a counter with HOLDOFF_CYCLES and go to HOLDOFF, or go directly to IDLE when the parameter is 0.
REQ-025 HOLDOFF SHALL decrement each cycle and go to IDLE when the counter reaches 1; no request is sampled in HOLDOFF.
REQ-026 Latency: with pipeEmpty=1 at acceptance in cycle 0, the trigger pulse SHALL occur in cycle 2.
REQ-027 interruptCode and interruptRetAddr SHALL be stable from acceptance through FIRE.

Reset
REQ-028 Asserting rst in any state SHALL force IDLE immediately, clear the counter and latches, and drive all outputs to 0.
REQ-029 A trap in progress when reset asserts SHALL be dropped, with no pulse after reset release.

Configuration
REQ-030 With RSD_TRAP_SEQ_EXT_INT_EN defined, the MEIP/MEIE term SHALL be included and the external interrupt code latched.
REQ-031 Without RSD_TRAP_SEQ_EXT_INT_EN, the external term SHALL be ignored and interruptCode SHALL be the constant timer code.

Structure
REQ-032 The TrapSeqState enum, the TrapKind enum and the HOLDOFF counter width typedef SHALL live in CSR_UnitTypes.
REQ-033 The interrupt selection (pending plus code choice) SHALL be one combinational sub-module, trap_int_select.

Verification
REQ-034 Timer interrupt: MIE=1, MTIE=1, MTIP=1 from cycle 0, pipeEmpty=1 -> flushReq in cycle 1, triggerInterrupt in cycle 2 with the timer code, redirectValid from cycle 3.
REQ-035 Simultaneous MEIP and MTIP, both enabled -> the latched code is external, one pulse only, and no second trap until the HOLDOFF_CYCLES=2 window has elapsed.
REQ-036 excptReq and pending in the same IDLE cycle -> triggerExcpt only, with intRetPC latched at acceptance.
REQ-037 Interrupt accepted, then mstatus.MIE cleared during DRAIN with pipeEmpty=0 -> return to IDLE with no pulse and busy=0 next cycle.
REQ-038 csrWriteReq and pending together in IDLE -> csrWriteGrant=1 and the interrupt is not accepted that cycle; rst asserted in REDIRECT -> all outputs 0 asynchronously.
